// File: rtl/nack_rd_arbiter.sv
// ============================================================================
// Module   : nack_rd_arbiter
// Purpose  : Round-robin share of one AXI4-style read adapter among
//            CLIENT_NUM requesters. Beat-counted completion; optional
//            watchdog under macro NACK_RD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nack_rd_arbiter #(
    parameter int CLIENT_NUM  = 4,
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 32,
    parameter int TLEN_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst_n,
    input  logic [CLIENT_NUM*ADDR_WIDTH-1:0] cli_araddr,
    input  logic [CLIENT_NUM*TLEN_WIDTH-1:0] cli_arlen,
    input  logic [CLIENT_NUM-1:0]            cli_arvalid,
    output logic [CLIENT_NUM-1:0]            cli_arready,
    output logic [DATA_WIDTH-1:0]            cli_rdata,
    output logic [CLIENT_NUM-1:0]            cli_rlast,
    output logic [CLIENT_NUM-1:0]            cli_rvalid,
    input  logic [CLIENT_NUM-1:0]            cli_rready,
    output logic [ADDR_WIDTH-1:0]            cmd_araddr,
    output logic [TLEN_WIDTH-1:0]            cmd_arlen,
    output logic                             cmd_arvalid,
    input  logic                             cmd_arready,
    input  logic [DATA_WIDTH-1:0]            cmd_rdata,
    input  logic                             cmd_rlast,
    input  logic                             cmd_rvalid,
    output logic                             cmd_rready,
    output logic                             err_trig,
    output logic [31:0]                      dfx_sta
);

    localparam int IDX_W = (CLIENT_NUM > 1) ? $clog2(CLIENT_NUM) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [CLIENT_NUM-1:0] grant;
    logic [TLEN_WIDTH:0]   beat_cnt;
    logic                  ar_done;
    logic [15:0]           done_cnt;
    logic [7:0]            stray_cnt;
    logic                  rlast_seen;
    logic [2:0]            last_idx;
    logic                  to_sticky;

    logic                  pick_vld;
    logic [IDX_W-1:0]      pick_idx;
    logic                  busy;
    logic                  beats_done;
    logic                  final_beat;
    logic                  route;
    logic                  beat_acc;
    logic                  stray;
    logic                  complete;
    logic                  to_hit;

    // Circular search starting at rr_ptr; first valid requester wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < CLIENT_NUM; k++) begin
            if (!pick_vld && cli_arvalid[(int'(rr_ptr) + k) % CLIENT_NUM]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'((int'(rr_ptr) + k) % CLIENT_NUM);
            end
        end
    end

    assign busy       = (state != S_IDLE);
    // beat_cnt can run one past arlen when all beats land before cmd_arready.
    assign beats_done = (beat_cnt > {1'b0, cmd_arlen});
    assign final_beat = (beat_cnt == {1'b0, cmd_arlen});
    assign route      = busy && !beats_done;
    assign cmd_rready = route && (|(cli_rready & grant));
    assign beat_acc   = cmd_rvalid && cmd_rready;
    assign stray      = (state == S_IDLE) && cmd_rvalid;
    assign complete   = busy && (ar_done || cmd_arready) &&
                        ((beat_acc && final_beat) || beats_done);

    assign cli_rdata   = cmd_rdata;
    assign cli_rvalid  = (route && cmd_rvalid) ? grant : '0;
    assign cli_rlast   = (route && cmd_rvalid && final_beat) ? grant : '0;
    assign cli_arready = ((state == S_IDLE) && pick_vld) ?
                         (CLIENT_NUM'(1) << pick_idx) : '0;

`ifdef NACK_RD_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_clr;

    assign to_clr = !busy || beat_acc || cmd_arready;
    assign to_hit = !to_clr && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt <= '0;
        end else if (to_clr || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            beat_cnt    <= '0;
            ar_done     <= 1'b0;
            cmd_araddr  <= '0;
            cmd_arlen   <= '0;
            cmd_arvalid <= 1'b0;
            err_trig    <= 1'b0;
            done_cnt    <= '0;
            stray_cnt   <= '0;
            rlast_seen  <= 1'b0;
            last_idx    <= '0;
            to_sticky   <= 1'b0;
        end else begin
            err_trig <= stray || to_hit;
            if (stray && (stray_cnt != 8'hFF)) begin
                stray_cnt <= stray_cnt + 8'd1;
            end
            if (to_hit) begin
                to_sticky <= 1'b1;
            end
            if (beat_acc) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (cmd_rlast) begin
                    rlast_seen <= 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        state       <= S_CMD;
                        cmd_araddr  <= cli_araddr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        cmd_arlen   <= cli_arlen[int'(pick_idx)*TLEN_WIDTH +: TLEN_WIDTH];
                        cmd_arvalid <= 1'b1;
                        grant       <= CLIENT_NUM'(1) << pick_idx;
                        rr_ptr      <= (int'(pick_idx) == CLIENT_NUM - 1) ? '0 : pick_idx + 1'b1;
                        last_idx    <= 3'(pick_idx);
                        rlast_seen  <= 1'b0;
                        beat_cnt    <= '0;
                        ar_done     <= 1'b0;
                    end
                end
                S_CMD, S_DATA: begin
                    if (complete || to_hit) begin
                        state       <= S_IDLE;
                        grant       <= '0;
                        ar_done     <= 1'b0;
                        beat_cnt    <= '0;
                        cmd_arvalid <= 1'b0;
                        if (complete) begin
                            done_cnt <= done_cnt + 16'd1;
                        end
                    end else if ((state == S_CMD) && cmd_arready) begin
                        state       <= S_DATA;
                        cmd_arvalid <= 1'b0;
                        ar_done     <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dfx_sta = {to_sticky, last_idx, 1'b0, rlast_seen, state, stray_cnt, done_cnt};

endmodule

`default_nettype wire
